count_arbiter: RTL and testbench

Two-requester round-robin controller for the shared 4-bit saturating step counter (counts 0..9, holds at 9). Each requester asks for a run to a target value. The arbiter grants one requester at a time, sequences the counter from 0 up to that target, and signals completion with a one-cycle done pulse. It sits between the two step consumers and the counter datapath, and owns Q.

---
 rtl/count_arbiter_if.sv | 33 +++
 rtl/count_arbiter.sv | 100 ++++++++++
 tb/tb_count_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/count_arbiter_if.sv
// Requester-side bundle for the shared step counter:
// request/target lines in, grant/done/counter value out.
interface count_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] tgt0;
    logic [WIDTH-1:0] tgt1;
    logic [1:0]       gnt;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] Q;

    modport master (
        output req,
        output tgt0,
        output tgt1,
        input  gnt,
        input  busy,
        input  done,
        input  Q
    );

    modport slave (
        input  req,
        input  tgt0,
        input  tgt1,
        output gnt,
        output busy,
        output done,
        output Q
    );
endinterface

// File: rtl/count_arbiter.sv
// Two-way round-robin owner of a saturating 0..MAXV step counter.
// A grant runs Q from 0 up to the latched target, then pulses done.
module count_arbiter #(
    parameter int MAXV  = 9,
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    count_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAXV);

    state_t           state;
    logic             owner;
    logic             last;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] q;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;

    logic             any;
    logic             win;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] clamp;
    logic [1:0]       onehot;

    // On a tie the requester that did not own last time wins.
    always_comb begin
        any    = |bus.req;
        win    = (bus.req == 2'b11) ? ~last : bus.req[1];
        sel    = win ? bus.tgt1 : bus.tgt0;
        clamp  = (sel > MAXQ) ? MAXQ : sel;
        onehot = win ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            tgt_r <= '0;
            q     <= '0;
            gnt   <= 2'b00;
            done  <= 2'b00;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (any) begin
                        owner <= win;
                        tgt_r <= clamp;
                        q     <= '0;
                        gnt   <= onehot;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!bus.req[owner]) begin
                        gnt   <= 2'b00;
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (q == tgt_r) begin
                        gnt   <= 2'b00;
                        done  <= gnt;
                        last  <= owner;
                        state <= DONE;
                    end else if (q < MAXQ) begin
                        q <= q + WIDTH'(1);
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    done  <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.done = done;
    assign bus.busy = busy;
    assign bus.Q    = q;
endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: runs, ties, clamp,
// abort, zero target, latched target and mid-run reset.
module tb_count_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    count_arbiter_if #(.WIDTH(4)) bus ();

    count_arbiter #(
        .MAXV (9),
        .WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the grant edge; returns just after the
    // edge that brings the arbiter back to IDLE.
    task automatic expect_run(input int g, input int t);
        for (int i = 0; i <= t; i++) begin
            chk("run_gnt", bus.gnt, g);
            chk("run_q", bus.Q, i);
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            step();
        end
        chk("fin_done", bus.done, g);
        chk("fin_gnt", bus.gnt, 0);
        chk("fin_busy", bus.busy, 1);
        chk("fin_q", bus.Q, t);
        step();
        chk("idle_done", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_gnt", bus.gnt, 0);
        chk("idle_q", bus.Q, t);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b0;
        bus.req  = 2'b00;
        bus.tgt0 = '0;
        bus.tgt1 = '0;
        step();
        step();
        chk("rst_q", bus.Q, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;

        // single run to 3
        bus.req  = 2'b01;
        bus.tgt0 = 4'd3;
        step();
        expect_run(1, 3);
        bus.req = 2'b00;
        step();
        chk("hold_q", bus.Q, 3);
        chk("hold_gnt", bus.gnt, 0);

        // fresh reset, then both held: 0,1,0,1
        rst = 1'b0;
        step();
        rst      = 1'b1;
        bus.req  = 2'b11;
        bus.tgt0 = 4'd2;
        bus.tgt1 = 4'd5;
        step();
        expect_run(1, 2);
        step();
        expect_run(2, 5);
        step();
        expect_run(1, 2);
        step();
        expect_run(2, 5);
        bus.req = 2'b00;

        // target 12 clamps to 9
        bus.req  = 2'b10;
        bus.tgt1 = 4'd12;
        step();
        expect_run(2, 9);
        bus.req = 2'b00;

        // abort at Q=4 with requester 1 pending
        bus.req  = 2'b01;
        bus.tgt0 = 4'd7;
        bus.tgt1 = 4'd5;
        step();
        for (int i = 0; i <= 4; i++) begin
            chk("ab_q", bus.Q, i);
            if (i < 4) step();
        end
        bus.req = 2'b10;
        step();
        chk("ab_gnt", bus.gnt, 0);
        chk("ab_done", bus.done, 0);
        chk("ab_q4", bus.Q, 4);
        chk("ab_busy", bus.busy, 0);
        step();
        chk("ab_gnt1", bus.gnt, 2);
        chk("ab_q0", bus.Q, 0);
        bus.req = 2'b00;
        step();
        chk("ab2_gnt", bus.gnt, 0);
        chk("ab2_done", bus.done, 0);

        // zero target, then target latched at grant
        bus.req  = 2'b01;
        bus.tgt0 = 4'd0;
        step();
        bus.tgt0 = 4'd6;
        expect_run(1, 0);
        bus.tgt0 = 4'd2;
        step();
        bus.tgt0 = 4'd6;
        expect_run(1, 2);

        // reset while Q=5; first tie after goes to 0
        bus.tgt0 = 4'd9;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("pre_q", bus.Q, 5);
        rst = 1'b0;
        step();
        chk("mr_q", bus.Q, 0);
        chk("mr_gnt", bus.gnt, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_busy", bus.busy, 0);
        rst     = 1'b1;
        bus.req = 2'b11;
        step();
        chk("mr_tie", bus.gnt, 1);
        chk("mr_tq", bus.Q, 0);
        bus.req = 2'b00;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
